// File: rtl/timer_mode_sequencer_if.sv
// Board-side signal bundle between the timer I/O and the mode sequencer.
// The master drives buttons, switches and datapath status; the slave drives strobes and the display controls.
interface timer_mode_sequencer_if;
  logic       set_btn;
  logic       start_btn;
  logic       tick;
  logic [3:0] sw_tens;
  logic [3:0] sw_ones;
  logic       count_zero;
  logic       load_sec;
  logic       load_min;
  logic [7:0] load_value;
  logic       run_en;
  logic       blank_sec;
  logic       blank_min;
  logic       alarm;
  logic [2:0] mode;

  modport master (
    output set_btn, start_btn, tick, sw_tens, sw_ones, count_zero,
    input  load_sec, load_min, load_value, run_en, blank_sec, blank_min, alarm, mode
  );

  modport slave (
    input  set_btn, start_btn, tick, sw_tens, sw_ones, count_zero,
    output load_sec, load_min, load_value, run_en, blank_sec, blank_min, alarm, mode
  );
endinterface

// File: rtl/timer_mode_sequencer.sv
// Mode FSM for the MM:SS countdown timer: button edge detect, switch clamping,
// digit-pair load strobes, run enable, edit-field blinking and a timed alarm.
module timer_mode_sequencer #(
  parameter int ALARM_TICKS  = 10,
  parameter int SEC_TENS_MAX = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  timer_mode_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    EDIT_SEC = 3'd1,
    EDIT_MIN = 3'd2,
    ARMED    = 3'd3,
    RUN      = 3'd4,
    PAUSE    = 3'd5,
    EXPIRED  = 3'd6
  } state_e;

  localparam logic [7:0] ALARM_MAX = 8'(ALARM_TICKS);
  localparam logic [3:0] TENS_MAX  = 4'(SEC_TENS_MAX);

  state_e     state, state_next;
  logic       set_q, start_q;
  logic       set_p, start_p;
  logic       blink_phase;
  logic       alarm_phase;
  logic [7:0] alarm_cnt;
  logic       changing;
  logic       alarm_done;

  assign set_p      = bus.set_btn & ~set_q;
  assign start_p    = bus.start_btn & ~start_q;
  assign changing   = (state_next != state);
  assign alarm_done = bus.tick && (alarm_cnt == ALARM_MAX - 8'd1);

  // NOTE: every state register is updated with <= so all flops sample the same pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      set_q       <= 1'b1;  // a button held through reset must not register as a press
      start_q     <= 1'b1;
      blink_phase <= 1'b0;
      alarm_phase <= 1'b0;
      alarm_cnt   <= 8'd0;
    end else begin
      state   <= state_next;
      set_q   <= bus.set_btn;
      start_q <= bus.start_btn;

      // Entry clears win over a coincident tick; ticks only count within a steady state.
      if (changing && (state_next == EDIT_SEC || state_next == EDIT_MIN))
        blink_phase <= 1'b0;
      else if (!changing && bus.tick && (state == EDIT_SEC || state == EDIT_MIN))
        blink_phase <= ~blink_phase;

      if (changing && state_next == EXPIRED) begin
        alarm_phase <= 1'b0;
        alarm_cnt   <= 8'd0;
      end else if (!changing && bus.tick && state == EXPIRED) begin
        alarm_phase <= ~alarm_phase;
        if (alarm_cnt != ALARM_MAX)
          alarm_cnt <= alarm_cnt + 8'd1;
      end
    end
  end

  // NOTE: state_next gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:     if (set_p) state_next = EDIT_SEC;
      EDIT_SEC: if (set_p) state_next = EDIT_MIN;
      EDIT_MIN: if (set_p) state_next = ARMED;
      ARMED: begin
        if (set_p)                           state_next = EDIT_SEC;
        else if (start_p && !bus.count_zero) state_next = RUN;
      end
      RUN: begin
        if (bus.count_zero) state_next = EXPIRED;
        else if (start_p)   state_next = PAUSE;
      end
      PAUSE: begin
        if (set_p)        state_next = EDIT_SEC;
        else if (start_p) state_next = RUN;
      end
      EXPIRED:  if (alarm_done || set_p || start_p) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  logic [3:0] ones_clamp, tens_clamp;

  always_comb begin
    ones_clamp = (bus.sw_ones > 4'd9) ? 4'd9 : bus.sw_ones;
    if (state == EDIT_SEC)
      tens_clamp = (bus.sw_tens > TENS_MAX) ? TENS_MAX : bus.sw_tens;
    else
      tens_clamp = (bus.sw_tens > 4'd9) ? 4'd9 : bus.sw_tens;
  end

  assign bus.load_value = {tens_clamp, ones_clamp};
  assign bus.load_sec   = (state == EDIT_SEC);
  assign bus.load_min   = (state == EDIT_MIN);
  assign bus.run_en     = (state == RUN);
  assign bus.blank_sec  = (state == EDIT_SEC) & blink_phase;
  assign bus.blank_min  = (state == EDIT_MIN) & blink_phase;
  assign bus.alarm      = (state == EXPIRED) & ~alarm_phase;
  assign bus.mode       = state;

endmodule

// File: tb/tb_timer_mode_sequencer.sv
// Directed bench for timer_mode_sequencer with ALARM_TICKS=3; expected values are hand-computed.
module tb_timer_mode_sequencer;

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_bad = 0;

  timer_mode_sequencer_if bus ();

  timer_mode_sequencer #(.ALARM_TICKS(3), .SEC_TENS_MAX(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic press_set();
    bus.set_btn = 1'b1; step();
    bus.set_btn = 1'b0; step();
  endtask

  task automatic press_start();
    bus.start_btn = 1'b1; step();
    bus.start_btn = 1'b0; step();
  endtask

  task automatic pulse_tick();
    bus.tick = 1'b1; step();
    bus.tick = 1'b0; step();
  endtask

  initial begin
    reset          = 1'b1;
    bus.set_btn    = 1'b1;
    bus.start_btn  = 1'b0;
    bus.tick       = 1'b0;
    bus.sw_tens    = 4'd7;
    bus.sw_ones    = 4'd12;
    bus.count_zero = 1'b0;
    step(); step();
    reset = 1'b0;
    repeat (5) step();
    check("held_set_mode", bus.mode, 3'd0);
    check("idle_outputs", {bus.load_sec, bus.load_min, bus.run_en, bus.blank_sec, bus.blank_min, bus.alarm}, 6'b0);
    check("idle_load_value", bus.load_value, 8'h79);

    bus.set_btn = 1'b0; step();
    check("released_mode", bus.mode, 3'd0);
    bus.set_btn = 1'b1; step();
    check("edit_sec_mode", bus.mode, 3'd1);
    check("edit_sec_load", {bus.load_sec, bus.load_min}, 2'b10);
    check("edit_sec_clamp", bus.load_value, 8'h59);
    check("edit_sec_blank0", bus.blank_sec, 1'b0);
    bus.set_btn = 1'b0; step();

    pulse_tick();
    check("blink_on", bus.blank_sec, 1'b1);
    pulse_tick();
    check("blink_off", bus.blank_sec, 1'b0);
    pulse_tick();
    press_start();
    check("edit_sec_start_ignored", bus.mode, 3'd1);

    press_set();
    check("edit_min_mode", bus.mode, 3'd2);
    check("edit_min_load", {bus.load_sec, bus.load_min}, 2'b01);
    check("edit_min_clamp", bus.load_value, 8'h79);
    check("edit_min_blank_cleared", bus.blank_min, 1'b0);
    pulse_tick();
    check("edit_min_blink", {bus.blank_sec, bus.blank_min}, 2'b01);

    press_set();
    check("armed_mode", bus.mode, 3'd3);
    bus.count_zero = 1'b1;
    press_start();
    check("armed_zero_ignored", bus.mode, 3'd3);
    bus.count_zero = 1'b0;
    press_start();
    check("run_mode", bus.mode, 3'd4);
    check("run_en", bus.run_en, 1'b1);

    press_set();
    check("run_set_ignored", bus.mode, 3'd4);
    press_start();
    check("pause_mode", bus.mode, 3'd5);
    check("pause_run_en", bus.run_en, 1'b0);
    press_start();
    check("resume_mode", bus.mode, 3'd4);

    bus.count_zero = 1'b1;
    press_start();
    bus.count_zero = 1'b0;
    check("expire_wins_mode", bus.mode, 3'd6);
    check("expire_run_en", bus.run_en, 1'b0);
    check("alarm_t0", bus.alarm, 1'b1);
    pulse_tick();
    check("alarm_t1", bus.alarm, 1'b0);
    check("expired_t1_mode", bus.mode, 3'd6);
    pulse_tick();
    check("alarm_t2", bus.alarm, 1'b1);
    check("expired_t2_mode", bus.mode, 3'd6);
    pulse_tick();
    check("alarm_timeout_mode", bus.mode, 3'd0);
    check("alarm_timeout_alarm", bus.alarm, 1'b0);

    press_set(); press_set(); press_set();
    press_start();
    check("rerun_mode", bus.mode, 3'd4);
    bus.count_zero = 1'b1; step();
    bus.count_zero = 1'b0;
    check("re_expired_mode", bus.mode, 3'd6);
    pulse_tick();
    check("re_alarm_t1", bus.alarm, 1'b0);
    press_set();
    check("expired_set_exit", bus.mode, 3'd0);

    press_set(); press_set(); press_set();
    press_start(); press_start();
    check("pause_again", bus.mode, 3'd5);
    press_set();
    check("pause_set_edit", bus.mode, 3'd1);
    press_set(); press_set();
    press_start();
    check("run_before_reset", bus.mode, 3'd4);
    reset = 1'b1; step();
    reset = 1'b0;
    check("reset_mid_run_mode", bus.mode, 3'd0);
    check("reset_mid_run_en", bus.run_en, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
